arp_frame_tx: RTL and testbench
===============================

Name: arp_frame_tx

Overview:
Parametrised ARP frame transmitter. Serialises one complete Ethernet II ARP frame per accepted request onto an 8-bit GMII-style byte stream: preamble/SFD, MAC header, optional 802.1Q tag, 28-byte ARP payload, zero pad and FCS. Request fields are latched at acceptance, a valid/ready handshake replaces level-enable, and a programmable inter-frame gap is enforced. Sits between the ARP responder/requester logic and the MAC byte-stream mux.

Parameters:
IFG_CYCLES, 12, idle cycles with o_tx_en low after the last FCS byte before o_ready rises; legal range 1..255.
VLAN_EN, 0, 1 inserts the 802.1Q tag 0x8100 + i_vlan_tci after the source MAC.
CNT_W, 16, width of the sent-frame counter.

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
i_valid  in  1  request strobe; accepted when i_valid && o_ready
o_ready  out  1  block idle and able to accept a request
i_dst_mac  in  48  Ethernet destination MAC
i_src_mac  in  48  Ethernet source MAC
i_vlan_tci  in  16  VLAN TCI; ignored when VLAN_EN=0
i_oper  in  16  ARP opcode (1 = request, 2 = reply)
i_sha  in  48  ARP sender hardware address
i_spa  in  32  ARP sender protocol address
i_tha  in  48  ARP target hardware address
i_tpa  in  32  ARP target protocol address
o_data  out  8  transmit byte
o_tx_en  out  1  o_data valid
o_done  out  1  one-cycle pulse on frame completion
o_frame_cnt  out  CNT_W  count of completed frames; wraps

Behaviour:
- Reset values: state IDLE, o_tx_en=0, o_data=0x00, o_done=0, o_frame_cnt=0, latched fields=0. o_ready is decoded from state, so it is 1 during and after reset.
- Acceptance:
  - Handshake at edge T when i_valid && o_ready; all request inputs are captured into registers at T.
  - Input changes after T have no effect on the frame in flight.
  - o_ready falls at T (combinational from state).
- Latency: first preamble byte appears with o_tx_en=1 in the cycle after T.
- States and byte counts, MSB/first-on-wire byte first:
  - PREAMBLE 8: 55 55 55 55 55 55 55 D5
  - DST 6
  - SRC 6
  - VLAN 4 (81 00 TCI_hi TCI_lo), only when VLAN_EN=1
  - ETYPE 2: 08 06
  - ARP 28: 00 01 08 00 06 04 oper_hi oper_lo, then SHA(6), SPA(4), THA(6), TPA(4)
  - PAD: 18 zero bytes (VLAN_EN=0) or 14 (VLAN_EN=1)
  - FCS 4
  - IFG: IFG_CYCLES cycles
  - then back to IDLE
- Frame length: o_tx_en stays high for exactly 72 contiguous cycles in both modes. The frame is 64 bytes after the SFD including FCS, which meets the 802.1Q minimum when tagged.
- FCS:
  - IEEE 802.3 CRC-32, reflected polynomial 0xEDB88320, seed 0xFFFFFFFF.
  - Covers DST through PAD; preamble/SFD excluded.
  - Transmitted as the complemented CRC, least significant byte first.
  - The CRC engine updates on each covered byte; the FCS value is stable from the first FCS cycle.
- o_data = 0x00 whenever o_tx_en=0.
- Completion:
  - o_done pulses in the first IFG cycle.
  - o_frame_cnt increments in that same cycle and wraps to 0 at 2^CNT_W.
- o_ready returns to 1 after the IFG, i.e. 72 + IFG_CYCLES cycles after T.
- Back-to-back: i_valid held high sends frames spaced exactly IFG_CYCLES idle cycles apart; there are no extra bubbles.
- Mid-frame rst_n assertion:
  - o_tx_en drops immediately (asynchronous); the truncated frame is discarded.
  - No o_done pulse; o_frame_cnt is cleared.
- i_valid during a frame or IFG is ignored (not queued).

Decomposition:
- Package eth_pkg: state enum; constants ETH_PREAMBLE=64'h55555555555555D5, ETYPE_ARP=16'h0806, ETYPE_VLAN=16'h8100, ARP_HTYPE_ETH=16'h0001, ARP_PTYPE_IPV4=16'h0800, ARP_HLEN=8'd6, ARP_PLEN=8'd4, CRC32_POLY, CRC32_SEED, MIN_FRAME_LEN=64.
- Sub-module eth_crc32_byte: one byte per cycle, with init, enable and data inputs and a running-CRC output. It is reused by the future IP/UDP transmitters.
- The top level holds the FSM, a byte counter within each state, the request latch and the IFG counter.

Test Plan:
1. VLAN_EN=0. Request with dst=FF:FF:FF:FF:FF:FF, src=sha=02:00:00:00:00:01, spa=C0A80001, tha=0, tpa=C0A80002, oper=1 -> 72 contiguous tx_en cycles with bytes 55x7, D5, FF x6, 02 00 00 00 00 01, 08 06, 00 01 08 00 06 04 00 01 ... C0 A8 00 02, 18x00. FCS equals the software model value, LSB first.
2. Same request with VLAN_EN=1 and tci=0x0064 -> bytes 81 00 00 64 follow the source MAC, pad is 14 bytes, tx_en is still 72 cycles, FCS matches the model.
3. i_valid held high for 3 frames with IFG_CYCLES=12 -> exactly 12 idle cycles between frames, three o_done pulses, o_frame_cnt=3.
4. All request inputs changed one cycle after acceptance -> transmitted frame matches the originally captured values.
5. rst_n pulsed low at byte 40 -> o_tx_en low asynchronously, no o_done, o_ready=1 and o_frame_cnt=0 after release; the next request produces a full correct frame.
6. CNT_W=2, 5 frames -> o_frame_cnt sequence 1,2,3,0,1. i_valid pulses during a frame are ignored, and only acknowledged requests are sent.

Source files
------------

// File: rtl/eth_pkg.sv
// Ethernet framing constants, transmitter state encoding and request bundle.
// Shared by the ARP transmitter and the future IP/UDP transmitters.
package eth_pkg;

   typedef enum logic [3:0] {
      S_IDLE,
      S_PRE,
      S_DST,
      S_SRC,
      S_VLAN,
      S_ETYPE,
      S_ARP,
      S_PAD,
      S_FCS,
      S_IFG
   } state_t;

   typedef struct packed {
      logic [47:0] dst;
      logic [47:0] src;
      logic [15:0] tci;
      logic [15:0] oper;
      logic [47:0] sha;
      logic [31:0] spa;
      logic [47:0] tha;
      logic [31:0] tpa;
   } arp_req_t;

   localparam logic [63:0] ETH_PREAMBLE   = 64'h55555555555555D5;
   localparam logic [15:0] ETYPE_ARP      = 16'h0806;
   localparam logic [15:0] ETYPE_VLAN     = 16'h8100;
   localparam logic [15:0] ARP_HTYPE_ETH  = 16'h0001;
   localparam logic [15:0] ARP_PTYPE_IPV4 = 16'h0800;
   localparam logic [7:0]  ARP_HLEN       = 8'd6;
   localparam logic [7:0]  ARP_PLEN       = 8'd4;
   localparam logic [31:0] CRC32_POLY     = 32'hEDB88320;
   localparam logic [31:0] CRC32_SEED     = 32'hFFFFFFFF;
   localparam int          MIN_FRAME_LEN  = 64;

   // 28-byte ARP body, first-on-wire byte in the top bits.
   function automatic logic [223:0] arp_payload(input arp_req_t r);
      return {ARP_HTYPE_ETH, ARP_PTYPE_IPV4, ARP_HLEN, ARP_PLEN,
              r.oper, r.sha, r.spa, r.tha, r.tpa};
   endfunction

endpackage

// File: rtl/eth_crc32_byte.sv
// Byte-serial IEEE 802.3 CRC-32 (reflected), one byte per enabled cycle.
// Ports: clk, rst_n, init (reload seed), en, data[7:0], crc[31:0] running value.
module eth_crc32_byte
   import eth_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        init,
   input  logic        en,
   input  logic [7:0]  data,
   output logic [31:0] crc
);

   logic [31:0] crc_nxt;

   always_comb begin
      crc_nxt = crc ^ {24'h0, data};
      for (int b = 0; b < 8; b++) begin
         crc_nxt = crc_nxt[0] ? ((crc_nxt >> 1) ^ CRC32_POLY)
                              : (crc_nxt >> 1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    crc <= CRC32_SEED;
      else if (init) crc <= CRC32_SEED;
      else if (en)   crc <= crc_nxt;
   end

endmodule

// File: rtl/arp_frame_tx.sv
// ARP frame transmitter: one padded Ethernet II ARP frame per accepted request.
// Ports: clk, rst_n, i_valid/o_ready request handshake, request fields i_*,
// byte stream o_data/o_tx_en, o_done completion pulse, o_frame_cnt frame count.
module arp_frame_tx
   import eth_pkg::*;
#(
   parameter int IFG_CYCLES = 12,
   parameter int VLAN_EN    = 0,
   parameter int CNT_W      = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [47:0]      i_dst_mac,
   input  logic [47:0]      i_src_mac,
   input  logic [15:0]      i_vlan_tci,
   input  logic [15:0]      i_oper,
   input  logic [47:0]      i_sha,
   input  logic [31:0]      i_spa,
   input  logic [47:0]      i_tha,
   input  logic [31:0]      i_tpa,
   output logic [7:0]       o_data,
   output logic             o_tx_en,
   output logic             o_done,
   output logic [CNT_W-1:0] o_frame_cnt
);

   // Pad brings DST..PAD up to the 60 bytes that precede the FCS.
   localparam int PAD_LEN =
      MIN_FRAME_LEN - 4 - 12 - 2 - 28 - ((VLAN_EN != 0) ? 4 : 0);

   state_t         state, state_nxt;
   logic [7:0]     cnt;
   logic [7:0]     len;
   logic           last;
   logic           accept;
   int             ci;
   arp_req_t       req;
   logic [223:0]   arp;
   logic [31:0]    vlan_tag;
   logic [31:0]    crc;
   logic           crc_en;

   assign accept   = i_valid && o_ready;
   assign ci       = int'(cnt);
   assign arp      = arp_payload(req);
   assign vlan_tag = {ETYPE_VLAN, req.tci};
   assign last     = (cnt == len - 8'd1);

   always_comb begin
      len = 8'd1;
      unique case (state)
         S_PRE:   len = 8'd8;
         S_DST:   len = 8'd6;
         S_SRC:   len = 8'd6;
         S_VLAN:  len = 8'd4;
         S_ETYPE: len = 8'd2;
         S_ARP:   len = 8'd28;
         S_PAD:   len = 8'(PAD_LEN);
         S_FCS:   len = 8'd4;
         S_IFG:   len = 8'(IFG_CYCLES);
         default: len = 8'd1;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         if (state == S_IDLE || last) cnt <= '0;
         else                         cnt <= cnt + 8'd1;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE:  if (accept) state_nxt = S_PRE;
         S_PRE:   if (last) state_nxt = S_DST;
         S_DST:   if (last) state_nxt = S_SRC;
         S_SRC:   if (last) state_nxt = (VLAN_EN != 0) ? S_VLAN : S_ETYPE;
         S_VLAN:  if (last) state_nxt = S_ETYPE;
         S_ETYPE: if (last) state_nxt = S_ARP;
         S_ARP:   if (last) state_nxt = S_PAD;
         S_PAD:   if (last) state_nxt = S_FCS;
         S_FCS:   if (last) state_nxt = S_IFG;
         // Accepting in the final gap cycle avoids an idle bubble.
         S_IFG:   if (last) state_nxt = accept ? S_PRE : S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      o_data  = 8'h00;
      o_tx_en = 1'b0;
      o_done  = 1'b0;
      o_ready = 1'b0;
      crc_en  = 1'b0;
      unique case (state)
         S_IDLE: o_ready = 1'b1;
         S_PRE: begin
            o_tx_en = 1'b1;
            o_data  = ETH_PREAMBLE[8*(7-ci) +: 8];
         end
         S_DST: begin
            o_tx_en = 1'b1;
            crc_en  = 1'b1;
            o_data  = req.dst[8*(5-ci) +: 8];
         end
         S_SRC: begin
            o_tx_en = 1'b1;
            crc_en  = 1'b1;
            o_data  = req.src[8*(5-ci) +: 8];
         end
         S_VLAN: begin
            o_tx_en = 1'b1;
            crc_en  = 1'b1;
            o_data  = vlan_tag[8*(3-ci) +: 8];
         end
         S_ETYPE: begin
            o_tx_en = 1'b1;
            crc_en  = 1'b1;
            o_data  = ETYPE_ARP[8*(1-ci) +: 8];
         end
         S_ARP: begin
            o_tx_en = 1'b1;
            crc_en  = 1'b1;
            o_data  = arp[8*(27-ci) +: 8];
         end
         S_PAD: begin
            o_tx_en = 1'b1;
            crc_en  = 1'b1;
         end
         S_FCS: begin
            o_tx_en = 1'b1;
            o_data  = ~crc[8*ci +: 8];
         end
         S_IFG: begin
            o_done  = (cnt == 8'd0);
            o_ready = last;
         end
         default: o_data = 8'h00;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      req <= '0;
      else if (accept) req <= '{dst: i_dst_mac, src: i_src_mac,
                                 tci: i_vlan_tci, oper: i_oper,
                                 sha: i_sha, spa: i_spa,
                                 tha: i_tha, tpa: i_tpa};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                     o_frame_cnt <= '0;
      else if (state == S_FCS && last) o_frame_cnt <= o_frame_cnt + CNT_W'(1);
   end

   eth_crc32_byte u_crc (
      .clk   (clk),
      .rst_n (rst_n),
      .init  (accept),
      .en    (crc_en),
      .data  (o_data),
      .crc   (crc)
   );

endmodule

// File: tb/tb_arp_frame_tx.sv
// Self-checking bench for arp_frame_tx: untagged/16-bit-count and tagged/2-bit-count
// instances driven from shared request inputs, checked against a frame-builder model.
module tb_arp_frame_tx;

   typedef struct {
      logic [47:0] dst;
      logic [47:0] src;
      logic [15:0] tci;
      logic [15:0] oper;
      logic [47:0] sha;
      logic [31:0] spa;
      logic [47:0] tha;
      logic [31:0] tpa;
   } req_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic valid_a = 1'b0;
   logic valid_b = 1'b0;
   logic sel = 1'b0;
   logic [47:0] dst = '0, src = '0, sha = '0, tha = '0;
   logic [15:0] tci = '0, oper = '0;
   logic [31:0] spa = '0, tpa = '0;

   logic        a_ready, a_tx_en, a_done;
   logic [7:0]  a_data;
   logic [15:0] a_cnt;
   logic        b_ready, b_tx_en, b_done;
   logic [7:0]  b_data;
   logic [1:0]  b_cnt;

   logic        d_ready, d_tx_en, d_done;
   logic [7:0]  d_data;
   logic [15:0] d_cnt;

   assign d_ready = sel ? b_ready : a_ready;
   assign d_tx_en = sel ? b_tx_en : a_tx_en;
   assign d_done  = sel ? b_done  : a_done;
   assign d_data  = sel ? b_data  : a_data;
   assign d_cnt   = sel ? {14'd0, b_cnt} : a_cnt;

   int n_cmp = 0;
   int n_err = 0;
   int exp_cnt[2];
   logic [7:0] exp_q[$];
   logic [7:0] got_q[$];

   always #5 clk = ~clk;

   arp_frame_tx #(.IFG_CYCLES(12), .VLAN_EN(0), .CNT_W(16)) dut_a (
      .clk(clk), .rst_n(rst_n), .i_valid(valid_a), .o_ready(a_ready),
      .i_dst_mac(dst), .i_src_mac(src), .i_vlan_tci(tci), .i_oper(oper),
      .i_sha(sha), .i_spa(spa), .i_tha(tha), .i_tpa(tpa),
      .o_data(a_data), .o_tx_en(a_tx_en), .o_done(a_done),
      .o_frame_cnt(a_cnt)
   );

   arp_frame_tx #(.IFG_CYCLES(12), .VLAN_EN(1), .CNT_W(2)) dut_b (
      .clk(clk), .rst_n(rst_n), .i_valid(valid_b), .o_ready(b_ready),
      .i_dst_mac(dst), .i_src_mac(src), .i_vlan_tci(tci), .i_oper(oper),
      .i_sha(sha), .i_spa(spa), .i_tha(tha), .i_tpa(tpa),
      .o_data(b_data), .o_tx_en(b_tx_en), .o_done(b_done),
      .o_frame_cnt(b_cnt)
   );

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic req_t rand_req();
      req_t r;
      r.dst  = 48'({$urandom(), $urandom()});
      r.src  = 48'({$urandom(), $urandom()});
      r.tci  = 16'($urandom());
      r.oper = 16'($urandom_range(1, 2));
      r.sha  = 48'({$urandom(), $urandom()});
      r.spa  = $urandom();
      r.tha  = 48'({$urandom(), $urandom()});
      r.tpa  = $urandom();
      return r;
   endfunction

   task automatic apply(input req_t r);
      dst = r.dst; src = r.src; tci = r.tci; oper = r.oper;
      sha = r.sha; spa = r.spa; tha = r.tha; tpa = r.tpa;
   endtask

   // Reference frame: byte list from the framing rules, CRC over the payload bits.
   task automatic build_exp(input req_t r, input bit vlan);
      logic [31:0] c;
      exp_q.delete();
      for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
      exp_q.push_back(8'hD5);
      for (int i = 5; i >= 0; i--) exp_q.push_back(r.dst[8*i +: 8]);
      for (int i = 5; i >= 0; i--) exp_q.push_back(r.src[8*i +: 8]);
      if (vlan) begin
         exp_q.push_back(8'h81); exp_q.push_back(8'h00);
         exp_q.push_back(r.tci[15:8]); exp_q.push_back(r.tci[7:0]);
      end
      exp_q.push_back(8'h08); exp_q.push_back(8'h06);
      exp_q.push_back(8'h00); exp_q.push_back(8'h01);
      exp_q.push_back(8'h08); exp_q.push_back(8'h00);
      exp_q.push_back(8'h06); exp_q.push_back(8'h04);
      exp_q.push_back(r.oper[15:8]); exp_q.push_back(r.oper[7:0]);
      for (int i = 5; i >= 0; i--) exp_q.push_back(r.sha[8*i +: 8]);
      for (int i = 3; i >= 0; i--) exp_q.push_back(r.spa[8*i +: 8]);
      for (int i = 5; i >= 0; i--) exp_q.push_back(r.tha[8*i +: 8]);
      for (int i = 3; i >= 0; i--) exp_q.push_back(r.tpa[8*i +: 8]);
      while (exp_q.size() < 8 + 60) exp_q.push_back(8'h00);
      c = 32'hFFFFFFFF;
      for (int i = 8; i < exp_q.size(); i++) begin
         c = c ^ {24'h0, exp_q[i]};
         for (int b = 0; b < 8; b++)
            c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      end
      c = ~c;
      for (int i = 0; i < 4; i++) exp_q.push_back(c[8*i +: 8]);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      exp_cnt[0] = 0;
      exp_cnt[1] = 0;
   endtask

   // Presents a request until accepted, then scrambles all inputs.
   task automatic send(input bit s, input req_t r, output bit ok, output logic first_tx);
      logic acc;
      acc = 1'b0;
      @(negedge clk);
      apply(r);
      if (s) valid_b = 1'b1;
      else   valid_a = 1'b1;
      for (int t = 0; t < 400; t++) begin
         acc = d_ready;
         @(posedge clk);
         if (acc) break;
         @(negedge clk);
      end
      ok = acc;
      @(negedge clk);
      first_tx = d_tx_en;
      valid_a = 1'b0;
      valid_b = 1'b0;
      apply(rand_req());
   endtask

   task automatic capture(output int n_done_in, output logic done_end,
                          output logic [15:0] cnt_end, output bit tmo);
      int t;
      got_q.delete();
      n_done_in = 0; done_end = 1'b0; cnt_end = '0; tmo = 1'b0; t = 0;
      @(negedge clk);
      while (d_tx_en !== 1'b1 && t < 500) begin
         @(negedge clk);
         t++;
      end
      if (d_tx_en !== 1'b1) begin
         tmo = 1'b1;
         return;
      end
      while (d_tx_en === 1'b1 && got_q.size() < 200) begin
         got_q.push_back(d_data);
         if (d_done === 1'b1) n_done_in++;
         @(negedge clk);
      end
      done_end = d_done;
      cnt_end  = d_cnt;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++; if (a_tx_en !== 1'b0 || b_tx_en !== 1'b0) begin n_err++;
         $display("FAIL rst_tx_en: got %b/%b required 0/0", a_tx_en, b_tx_en); end
      n_cmp++; if (a_ready !== 1'b1 || b_ready !== 1'b1) begin n_err++;
         $display("FAIL rst_ready_low: got %b/%b required 1/1", a_ready, b_ready); end
      rst_n = 1'b1;
      exp_cnt[0] = 0;
      exp_cnt[1] = 0;
      @(negedge clk);
      n_cmp++; if (a_data !== 8'h00 || b_data !== 8'h00) begin n_err++;
         $display("FAIL rst_data: got %h/%h required 00/00", a_data, b_data); end
      n_cmp++; if (a_done !== 1'b0 || b_done !== 1'b0) begin n_err++;
         $display("FAIL rst_done: got %b/%b required 0/0", a_done, b_done); end
      n_cmp++; if (a_cnt !== 16'd0 || b_cnt !== 2'd0) begin n_err++;
         $display("FAIL rst_cnt: got %0d/%0d required 0/0", a_cnt, b_cnt); end
      n_cmp++; if (a_ready !== 1'b1 || b_ready !== 1'b1) begin n_err++;
         $display("FAIL rst_ready: got %b/%b required 1/1", a_ready, b_ready); end
   endtask

   // Fixed plan requests on both instances, then random ones.
   task automatic test_frames();
      req_t r;
      bit ok, tmo, s;
      logic ft, de;
      int nd;
      logic [15:0] ce, ec;
      for (int k = 0; k < 8; k++) begin
         if (k < 2) begin
            s = k[0];
            r.dst = 48'hFFFFFFFFFFFF; r.src = 48'h020000000001;
            r.sha = 48'h020000000001; r.spa = 32'hC0A80001;
            r.tha = 48'h0; r.tpa = 32'hC0A80002;
            r.oper = 16'd1; r.tci = 16'h0064;
         end else begin
            s = 1'($urandom_range(0, 1));
            r = rand_req();
         end
         sel = s;
         build_exp(r, s);
         fork
            send(s, r, ok, ft);
            capture(nd, de, ce, tmo);
         join
         exp_cnt[s]++;
         ec = s ? 16'(exp_cnt[s] % 4) : 16'(exp_cnt[s] % 65536);
         n_cmp++; if (!ok || tmo) begin n_err++;
            $display("FAIL frame%0d_handshake: ok=%0d timeout=%0d required 1/0", k, ok, tmo); end
         n_cmp++; if (ft !== 1'b1) begin n_err++;
            $display("FAIL frame%0d_latency: tx_en %b required 1", k, ft); end
         n_cmp++; if (got_q.size() != 72) begin n_err++;
            $display("FAIL frame%0d_len: got %0d required 72", k, got_q.size()); end
         for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_cmp++; if (got_q[i] !== exp_q[i]) begin n_err++;
               $display("FAIL frame%0d_byte%0d: got %h required %h", k, i, got_q[i], exp_q[i]); end
         end
         n_cmp++; if (de !== 1'b1 || nd != 0) begin n_err++;
            $display("FAIL frame%0d_done: end=%b in_frame=%0d required 1/0", k, de, nd); end
         n_cmp++; if (ce !== ec) begin n_err++;
            $display("FAIL frame%0d_cnt: got %0d required %0d", k, ce, ec); end
      end
   endtask

   task automatic test_back_to_back();
      int acc, hi, lo, ndone;
      bit drop, started, prev;
      int hi_runs[$];
      int lo_runs[$];
      acc = 0; hi = 0; lo = 0; ndone = 0;
      drop = 0; started = 0; prev = 0;
      do_reset();
      sel = 1'b0;
      apply(rand_req());
      @(negedge clk);
      valid_a = 1'b1;
      for (int t = 0; t < 600; t++) begin
         if (valid_a && a_ready) begin
            acc++;
            if (acc == 3) drop = 1;
         end
         @(posedge clk);
         @(negedge clk);
         if (drop) begin valid_a = 1'b0; drop = 0; end
         if (a_done === 1'b1) ndone++;
         if (a_tx_en === 1'b1) begin
            if (!prev && started) lo_runs.push_back(lo);
            started = 1;
            hi++;
         end else begin
            if (prev) begin hi_runs.push_back(hi); hi = 0; lo = 0; end
            lo++;
         end
         prev = (a_tx_en === 1'b1);
         if (hi_runs.size() == 3 && lo > 30) break;
      end
      valid_a = 1'b0;
      exp_cnt[0] = 3;
      n_cmp++; if (hi_runs.size() != 3 || acc != 3) begin n_err++;
         $display("FAIL b2b_frames: got %0d frames %0d accepts required 3/3", hi_runs.size(), acc); end
      foreach (hi_runs[i]) begin
         n_cmp++; if (hi_runs[i] != 72) begin n_err++;
            $display("FAIL b2b_len%0d: got %0d required 72", i, hi_runs[i]); end
      end
      n_cmp++; if (lo_runs.size() != 2) begin n_err++;
         $display("FAIL b2b_gaps: got %0d required 2", lo_runs.size()); end
      foreach (lo_runs[i]) begin
         n_cmp++; if (lo_runs[i] != 12) begin n_err++;
            $display("FAIL b2b_gap%0d: got %0d required 12", i, lo_runs[i]); end
      end
      n_cmp++; if (ndone != 3) begin n_err++;
         $display("FAIL b2b_done: got %0d required 3", ndone); end
      n_cmp++; if (a_cnt !== 16'd3) begin n_err++;
         $display("FAIL b2b_cnt: got %0d required 3", a_cnt); end
   endtask

   task automatic test_midframe_reset();
      req_t r;
      bit ok, tmo;
      logic ft, de;
      int nd, bad;
      logic [15:0] ce;
      sel = 1'b0;
      r = rand_req();
      send(1'b0, r, ok, ft);
      repeat (40) @(negedge clk);
      n_cmp++; if (a_tx_en !== 1'b1) begin n_err++;
         $display("FAIL mrst_active: tx_en %b required 1", a_tx_en); end
      #2 rst_n = 1'b0;
      #1;
      n_cmp++; if (a_tx_en !== 1'b0) begin n_err++;
         $display("FAIL mrst_async_tx_en: got %b required 0", a_tx_en); end
      n_cmp++; if (a_data !== 8'h00) begin n_err++;
         $display("FAIL mrst_data: got %h required 00", a_data); end
      n_cmp++; if (a_ready !== 1'b1 || a_cnt !== 16'd0) begin n_err++;
         $display("FAIL mrst_state: ready=%b cnt=%0d required 1/0", a_ready, a_cnt); end
      exp_cnt[0] = 0;
      exp_cnt[1] = 0;
      @(negedge clk);
      rst_n = 1'b1;
      bad = 0;
      repeat (100) begin
         @(negedge clk);
         if (a_tx_en !== 1'b0 || a_done !== 1'b0) bad++;
      end
      n_cmp++; if (bad != 0) begin n_err++;
         $display("FAIL mrst_quiet: got %0d active cycles required 0", bad); end
      n_cmp++; if (a_cnt !== 16'd0 || a_ready !== 1'b1) begin n_err++;
         $display("FAIL mrst_after: cnt=%0d ready=%b required 0/1", a_cnt, a_ready); end
      r = rand_req();
      build_exp(r, 1'b0);
      fork
         send(1'b0, r, ok, ft);
         capture(nd, de, ce, tmo);
      join
      exp_cnt[0]++;
      n_cmp++; if (!ok || tmo || got_q.size() != 72) begin n_err++;
         $display("FAIL mrst_frame_len: ok=%0d tmo=%0d len=%0d required 1/0/72", ok, tmo, got_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         n_cmp++; if (got_q[i] !== exp_q[i]) begin n_err++;
            $display("FAIL mrst_byte%0d: got %h required %h", i, got_q[i], exp_q[i]); end
      end
      n_cmp++; if (de !== 1'b1 || ce !== 16'd1) begin n_err++;
         $display("FAIL mrst_done_cnt: done=%b cnt=%0d required 1/1", de, ce); end
   endtask

   task automatic test_cnt_wrap();
      req_t r;
      bit ok, tmo;
      logic ft, de;
      int nd, extra;
      logic [15:0] ce, ec;
      do_reset();
      sel = 1'b1;
      for (int k = 0; k < 5; k++) begin
         r = rand_req();
         build_exp(r, 1'b1);
         fork
            begin
               send(1'b1, r, ok, ft);
               repeat (20) @(negedge clk);
               apply(rand_req());
               valid_b = 1'b1;
               @(negedge clk);
               valid_b = 1'b0;
            end
            capture(nd, de, ce, tmo);
         join
         exp_cnt[1]++;
         ec = 16'(exp_cnt[1] % 4);
         n_cmp++; if (!ok || tmo || got_q.size() != 72) begin n_err++;
            $display("FAIL wrap%0d_len: ok=%0d tmo=%0d len=%0d required 1/0/72", k, ok, tmo, got_q.size()); end
         for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_cmp++; if (got_q[i] !== exp_q[i]) begin n_err++;
               $display("FAIL wrap%0d_byte%0d: got %h required %h", k, i, got_q[i], exp_q[i]); end
         end
         n_cmp++; if (de !== 1'b1 || ce !== ec) begin n_err++;
            $display("FAIL wrap%0d_cnt: done=%b cnt=%0d required 1/%0d", k, de, ce, ec); end
      end
      extra = 0;
      repeat (150) begin
         @(negedge clk);
         if (b_tx_en !== 1'b0) extra++;
      end
      n_cmp++; if (extra != 0) begin n_err++;
         $display("FAIL wrap_ignored_valid: got %0d tx cycles required 0", extra); end
      n_cmp++; if (b_cnt !== 2'd1) begin n_err++;
         $display("FAIL wrap_final_cnt: got %0d required 1", b_cnt); end
   endtask

   initial begin
      test_reset();
      test_frames();
      test_back_to_back();
      test_midframe_reset();
      test_cnt_wrap();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
